// File: rtl/imm_extend_queue.sv
// Immediate extender (zero/sign/upper/branch) feeding a DEPTH-entry FIFO; results visible 1 cycle after push.
// Backpressure: in_ready drops when full, head holds stable while out_ready=0; both flags come from registered state.
module imm_extend_queue #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = DATA_W - IMM_W;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  logic [DATA_W-1:0] zext_dat;
  logic [DATA_W-1:0] sext_dat;
  logic [DATA_W-1:0] ext_dat;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;
  logic              pop;

  always_comb begin
    zext_dat = {{XW{1'b0}}, imm_in};
    sext_dat = {{XW{imm_in[IMM_W-1]}}, imm_in};
    ext_dat  = zext_dat;
    case (mode_e'(mode))
      MODE_ZERO:   ext_dat = zext_dat;
      MODE_SIGN:   ext_dat = sext_dat;
      MODE_UPPER:  ext_dat = {imm_in, {XW{1'b0}}};
      MODE_BRANCH: ext_dat = {sext_dat[DATA_W-3:0], 2'b00};
      default:     ext_dat = zext_dat;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Mask the head when empty so stale storage never leaks out.
  assign imm_out   = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= ext_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_queue.sv
// Directed + random bench for imm_extend_queue against a queue-based reference model.
module tb_imm_extend_queue;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IMM_W-1:0]  imm_in = '0;
  logic [1:0]        mode = 2'b00;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] imm_out;
  logic [2:0]        count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q[$];

  imm_extend_queue #(.IMM_W(IMM_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .imm_in(imm_in), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out), .count(count)
  );

  always #5 clk = ~clk;

  // Reference extension from plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input int unsigned imm, input int m);
    longint s;
    s = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
    case (m)
      0:       return 32'(imm);
      1:       return 32'(s);
      2:       return 32'(longint'(imm) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("count", 32'(count), 32'(q.size()));
    chk("imm_out", imm_out, (q.size() != 0) ? q[0] : 32'h0);
  endtask

  // Called at a negedge with inputs already driven; advances one cycle.
  task automatic tick();
    bit do_push, do_pop;
    logic [31:0] v;
    chk_model();
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() > 0);
    v = ref_ext(imm_in, int'(mode));
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(v);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [15:0] imm, input logic [1:0] m);
    in_valid = v;
    imm_in   = imm;
    mode     = m;
  endtask

  initial begin
    logic [15:0] t1_imm [4];
    logic [31:0] t1_exp [4];
    bit stalled;
    t1_exp[0] = 32'h00008001; t1_exp[1] = 32'hFFFF8001;
    t1_exp[2] = 32'h80010000; t1_exp[3] = 32'hFFFE0004;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_imm_out", imm_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x8001 in every mode, consumer always ready
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 16'h8001, 2'(m));
      tick();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_value", imm_out, t1_exp[m]);
      drive(1'b0, 16'h0, 2'b00);
      tick();
    end

    // Boundary extension values
    t1_imm[0] = 16'hFFFF; t1_exp[0] = 32'hFFFFFFFC;
    t1_imm[1] = 16'h0004; t1_exp[1] = 32'h00000010;
    t1_imm[2] = 16'h1234; t1_exp[2] = 32'h12340000;
    t1_imm[3] = 16'h7FFF; t1_exp[3] = 32'h00007FFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t1_imm[i], (i < 2) ? 2'b11 : ((i == 2) ? 2'b10 : 2'b01));
      tick();
      chk("t2_value", imm_out, t1_exp[i]);
      drive(1'b0, 16'h0, 2'b00);
      tick();
    end

    // Fill to full, fifth entry held by source until a slot frees
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom));
      tick();
    end
    chk("t3_count_full", 32'(count), 32'd4);
    drive(1'b1, 16'($urandom), 2'($urandom));
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    tick();
    chk("t3_count_after_pop", 32'(count), 32'd3);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_drained", 32'(count), 32'd0);

    // Steady state at count=2 with simultaneous push/pop
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom));
      tick();
      chk("t4_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Flush at count=3 with a push offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom));
      tick();
    end
    drive(1'b1, 16'h5A5A, 2'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_imm_out", imm_out, 32'h0);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset mid-burst at count=2
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom));
      tick();
    end
    chk("t6_pre_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_imm_out", imm_out, 32'h0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic with occasional flush; source holds data while stalled
    for (int i = 0; i < 400; i++) begin
      stalled = in_valid && (q.size() == DEPTH);
      if (!stalled) drive(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
